// File: rtl/vga_pkg.sv
// vga_pkg
//   Shared 640x480@60 raster constants for the VGA timing generator and the
//   game pixel generator downstream of it.
//   Contents:
//     - visible/porch/sync sizes and the derived line/frame totals
//     - sync window bounds (first count inside the pulse, first count after)
//     - default sync polarity and pixel divider
//     - counter type, registered control bundle and a window-decode helper
package vga_pkg;

    localparam int unsigned H_DISP  = 640;
    localparam int unsigned H_FP    = 16;
    localparam int unsigned H_SYNC  = 96;
    localparam int unsigned H_BP    = 48;
    localparam int unsigned H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_DISP  = 480;
    localparam int unsigned V_FP    = 10;
    localparam int unsigned V_SYNC  = 2;
    localparam int unsigned V_BP    = 33;
    localparam int unsigned V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

    // Sync pulses occupy [START, END) in counter space.
    localparam int unsigned HS_START = H_DISP + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_DISP + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    // 0 = active-low sync pulses (standard for 640x480@60).
    localparam bit          SYNC_POL = 1'b0;
    localparam int unsigned CLK_DIV  = 4;

    localparam int unsigned CNT_W   = 10;
    localparam int unsigned CNT_MAX = 1 << CNT_W;

    typedef logic [CNT_W-1:0] cnt_t;

    // Everything decoded from the next-state counters and registered with them.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic valid;
        logic frame_start;
        logic line_start;
    } vga_ctl_t;

    function automatic logic in_window(input int unsigned pos,
                                       input int unsigned lo,
                                       input int unsigned hi);
        return (pos >= lo) && (pos < hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_pixel_tick_div.sv
// pixel_tick_div
//   Divides the system clock down to the pixel rate. The divider counts
//   0..CLK_DIV-1 and wraps; tick is high while it sits at its last value, so
//   the consumer sees one tick every CLK_DIV clocks. With CLK_DIV = 1 the
//   divider is a single bit that never leaves 0 and tick is always high.
//   Ports:
//     clk    in   system clock
//     rst_n  in   asynchronous active-low reset (divider -> 0)
//     tick   out  pixel-rate tick, decoded from the divider register
module pixel_tick_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
        $error("pixel_tick_div: CLK_DIV must be in 1..16");
    end

    localparam int unsigned       DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    assign tick = (div_q == DIV_MAX);

    always_comb begin
        div_d = div_q + 1'b1;
        if (tick) begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   VGA raster timing from the 100 MHz system clock. A divide-by-CLK_DIV tick
//   advances the horizontal/vertical counters; sync, valid and the start
//   pulses are decoded from the next-state counts and registered on the same
//   edge, so every output lines up with h_cnt/v_cnt and nothing is
//   combinational from an input.
//   Ports:
//     clk          in   system clock
//     rst_n        in   asynchronous active-low reset
//     pclk_en      out  one-clk pulse in the cycle the counters hold a new pixel
//     h_cnt        out  horizontal position 0..H_TOTAL-1
//     v_cnt        out  vertical position 0..V_TOTAL-1
//     hsync        out  horizontal sync, active level SYNC_POL
//     vsync        out  vertical sync, active level SYNC_POL
//     valid        out  inside the visible area
//     frame_start  out  pulse with pclk_en when the counters become (0,0)
//     line_start   out  pulse with pclk_en when h_cnt becomes 0
module vga_timing_gen #(
    parameter int unsigned H_DISP   = vga_pkg::H_DISP,
    parameter int unsigned H_FP     = vga_pkg::H_FP,
    parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
    parameter int unsigned H_BP     = vga_pkg::H_BP,
    parameter int unsigned V_DISP   = vga_pkg::V_DISP,
    parameter int unsigned V_FP     = vga_pkg::V_FP,
    parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
    parameter int unsigned V_BP     = vga_pkg::V_BP,
    parameter int unsigned CLK_DIV  = vga_pkg::CLK_DIV,
    parameter bit          SYNC_POL = vga_pkg::SYNC_POL
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pclk_en,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       hsync,
    output logic       vsync,
    output logic       valid,
    output logic       frame_start,
    output logic       line_start
);

    import vga_pkg::*;

    localparam int unsigned H_TOT    = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT    = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_FIRST = H_DISP + H_FP;
    localparam int unsigned HS_AFTER = HS_FIRST + H_SYNC;
    localparam int unsigned VS_FIRST = V_DISP + V_FP;
    localparam int unsigned VS_AFTER = VS_FIRST + V_SYNC;

    if (H_TOT > CNT_MAX || V_TOT > CNT_MAX) begin : g_bad_totals
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must fit the 10-bit counters");
    end

    localparam cnt_t H_LAST    = cnt_t'(H_TOT - 1);
    localparam cnt_t V_LAST    = cnt_t'(V_TOT - 1);
    localparam logic SYNC_ACT  = SYNC_POL;
    localparam logic SYNC_IDLE = ~SYNC_POL;

    logic     tick;
    cnt_t     h_q, h_d;
    cnt_t     v_q, v_d;
    logic     pclk_en_q;
    vga_ctl_t ctl_q, ctl_d;

    pixel_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_div (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Counters start at the last position of a frame so the very first tick
    // lands on (0,0) and produces a clean frame_start.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (tick) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                if (v_q == V_LAST) begin
                    v_d = '0;
                end else begin
                    v_d = v_q + 1'b1;
                end
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    // Decoding the next-state counts keeps the registered controls aligned
    // with the registered counters. Between ticks h_d/v_d equal the current
    // counts, so the levels hold and the pulses drop to 0. vsync only moves
    // when v_d moves, which is the edge on which h wraps to 0.
    always_comb begin
        ctl_d.hsync       = in_window(32'(h_d), HS_FIRST, HS_AFTER) ? SYNC_ACT : SYNC_IDLE;
        ctl_d.vsync       = in_window(32'(v_d), VS_FIRST, VS_AFTER) ? SYNC_ACT : SYNC_IDLE;
        ctl_d.valid       = (32'(h_d) < H_DISP) && (32'(v_d) < V_DISP);
        ctl_d.line_start  = tick && (h_d == '0);
        ctl_d.frame_start = tick && (h_d == '0) && (v_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q               <= H_LAST;
            v_q               <= V_LAST;
            pclk_en_q         <= 1'b0;
            ctl_q.hsync       <= SYNC_IDLE;
            ctl_q.vsync       <= SYNC_IDLE;
            ctl_q.valid       <= 1'b0;
            ctl_q.frame_start <= 1'b0;
            ctl_q.line_start  <= 1'b0;
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            pclk_en_q <= tick;
            ctl_q     <= ctl_d;
        end
    end

    assign pclk_en     = pclk_en_q;
    assign h_cnt       = h_q;
    assign v_cnt       = v_q;
    assign hsync       = ctl_q.hsync;
    assign vsync       = ctl_q.vsync;
    assign valid       = ctl_q.valid;
    assign frame_start = ctl_q.frame_start;
    assign line_start  = ctl_q.line_start;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates 640x480@60 VGA raster timing: pixel-rate enable, h_cnt/v_cnt, hsync/vsync and display-valid.
- Sits directly upstream of the game pixel generator, which consumes h_cnt/v_cnt.
- Its sync/valid outputs also go to the board-level VGA pins and the final colour gate.
- Runs from the 100 MHz system clock, with pixel rate derived by a divide-by-CLK_DIV enable. No second clock domain.

Parameters:
- H_DISP, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch (H_TOTAL = 800)
- V_DISP, 480, visible lines per frame
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch (V_TOTAL = 525)
- CLK_DIV, 4, system clocks per pixel; legal range 1..16
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- pclk_en  out  1  one-clk pulse, high in the cycle counters hold a new pixel
- h_cnt  out  10  horizontal position, 0..H_TOTAL-1
- v_cnt  out  10  vertical position, 0..V_TOTAL-1
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- valid  out  1  high when h_cnt < H_DISP and v_cnt < V_DISP
- frame_start  out  1  one-clk pulse coincident with pclk_en when counters become (0,0)
- line_start  out  1  one-clk pulse coincident with pclk_en when h_cnt becomes 0

Behaviour:
- One clock domain. Reset is asynchronous and active-low on rst_n. All outputs are registered; no combinational path from any input to any output.
- Reset values:
  - divider = 0; h_cnt = H_TOTAL-1 (799); v_cnt = V_TOTAL-1 (524)
  - hsync = vsync = !SYNC_POL; valid = 0
  - pclk_en = frame_start = line_start = 0
- Divider:
  - Counts 0..CLK_DIV-1 and wraps. Internal tick = (divider == CLK_DIV-1).
  - CLK_DIV = 1 gives a tick every cycle.
- On each tick edge:
  - h_cnt increments; at H_TOTAL-1 it wraps to 0 and v_cnt increments.
  - v_cnt wraps from V_TOTAL-1 to 0 only when h_cnt also wraps.
- pclk_en is the registered tick, so it is high exactly in the cycle after the update, coincident with the new h_cnt/v_cnt.
- Decoding: hsync, vsync, valid, frame_start and line_start are decoded from the next-state counts and registered on the same edge, so they align with h_cnt/v_cnt.
- hsync = SYNC_POL when H_DISP+H_FP <= h_cnt < H_DISP+H_FP+H_SYNC (656..751), else !SYNC_POL.
- vsync = SYNC_POL when V_DISP+V_FP <= v_cnt < V_DISP+V_FP+V_SYNC (490..491), else !SYNC_POL. vsync changes only on the edge where h_cnt wraps to 0.
- Between ticks all outputs hold; the pulse outputs are 0.
- Start-up: the first tick after reset release moves counters from (799,524) to (0,0) and asserts valid, frame_start and line_start. This occurs CLK_DIV clocks after the first rising edge with rst_n high.
- Reset mid-frame: immediate asynchronous return to the reset values, then restart exactly as from power-up. No partial line is emitted.
- Widths: counters are 10 bits. Elaboration error if H_TOTAL > 1024, V_TOTAL > 1024, or CLK_DIV is outside 1..16.
- Frame totals: exactly H_TOTAL*V_TOTAL = 420000 pclk_en pulses and one frame_start per frame; CLK_DIV*420000 clocks per frame.

Decomposition:
- Shared package vga_pkg:
  - 640x480 timing constants and derived H_TOTAL/V_TOTAL
  - sync window bounds
  - SYNC_POL default
  - The game pixel generator uses the same H_DISP/V_DISP constants.
- One natural sub-module: pixel_tick_div (parameter CLK_DIV; ports clk, rst_n, tick). It holds the divider.

Test Plan:
- Reset hold, then release:
  - During reset: h_cnt=799, v_cnt=524, hsync=vsync=1, valid=0, pulses 0.
  - 4 clocks after release: pclk_en=1, h_cnt=0, v_cnt=0, valid=1, frame_start=1, line_start=1.
- hsync window, v=0:
  - h_cnt=655 gives hsync=1; 656 gives 0; 751 gives 0; 752 gives 1.
  - valid goes 1 to 0 at h_cnt=640.
- Line wrap: at h=799, v=10, next pclk_en gives h=0, v=11, line_start=1, frame_start=0.
- Frame wrap and vsync:
  - vsync=0 exactly for v_cnt 490 and 491, asserted from the h=0 edge.
  - (799,524) goes to (0,0) with frame_start=1.
  - Count 420000 pclk_en pulses and 1680000 clocks between successive frame_start pulses.
- Mid-frame reset:
  - Assert rst_n low at h=300, v=200 for a 1-clk glitch mid-divider.
  - Outputs go to reset values immediately (asynchronous) and restart at (0,0) 4 clocks after release.
- Parameter CLK_DIV=1: pclk_en is constantly 1 after release, and the counters advance every clock.
